// File: rtl/alu_exec_if.sv
// Valid/ready operand and result bus between ALU control, the execute stage and writeback.
interface alu_exec_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_control;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             illegal;

  modport master (
    output in_valid, alu_control, a, b, out_ready,
    input  in_ready, out_valid, result, zero, overflow, illegal
  );

  modport slave (
    input  in_valid, alu_control, a, b, out_ready,
    output in_ready, out_valid, result, zero, overflow, illegal
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute stage: registered ALU result with Zero/Overflow/Illegal flags and a valid/ready handshake.
// Define ALU_FAST_SHIFT_EN for a single-cycle barrel shifter; otherwise shifts iterate one bit per cycle.
module alu_exec_unit #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SHAMT_W = 4
) (
  input logic        clk,
  input logic        rst,
  alu_exec_if.slave  bus
);
  localparam int unsigned MSB = WIDTH - 1;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_SLT = 4'b0001;
  localparam logic [3:0] OP_OR  = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_SUB = 4'b1100;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
  logic               illegal_q, illegal_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   shreg, shreg_d;
  logic [SHAMT_W-1:0] cnt, cnt_d;
  logic               sra_q, sra_d;

  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   sum, diff, shifted;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_ovf, alu_ill, alu_multi, alu_sra;
  logic               accept;

  assign shamt   = bus.b[SHAMT_W-1:0];
  assign sum     = bus.a + bus.b;
  assign diff    = bus.a - bus.b;
  assign shifted = sra_q ? {shreg[MSB], shreg[MSB:1]} : {shreg[MSB-1:0], 1'b0};

  assign bus.in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = ovf_q;
  assign bus.illegal   = illegal_q;

  // Single-cycle datapath; alu_multi flags shifts that must go through the iterative shifter
  always_comb begin
    alu_res   = '0;
    alu_ovf   = 1'b0;
    alu_ill   = 1'b0;
    alu_multi = 1'b0;
    alu_sra   = 1'b0;
    case (bus.alu_control)
      OP_AND: alu_res = bus.a & bus.b;
      OP_SLT: alu_res = WIDTH'($signed(bus.a) < $signed(bus.b));
      OP_OR:  alu_res = bus.a | bus.b;
      OP_XOR: alu_res = bus.a ^ bus.b;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (bus.a[MSB] == bus.b[MSB]) && (sum[MSB] != bus.a[MSB]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (bus.a[MSB] != bus.b[MSB]) && (diff[MSB] != bus.a[MSB]);
      end
`ifdef ALU_FAST_SHIFT_EN
      OP_SLL: alu_res = bus.a << shamt;
      OP_SRA: begin
        alu_res = WIDTH'($signed(bus.a) >>> shamt);
        alu_sra = 1'b1;
      end
`else
      OP_SLL: begin
        alu_res   = bus.a;
        alu_multi = (shamt != '0);
      end
      OP_SRA: begin
        alu_res   = bus.a;
        alu_multi = (shamt != '0);
        alu_sra   = 1'b1;
      end
`endif
      default: alu_ill = 1'b1;
    endcase
  end

  // Next-state and output-register load logic
  always_comb begin
    state_d     = state;
    result_d    = result_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    illegal_d   = illegal_q;
    out_valid_d = out_valid_q;
    shreg_d     = shreg;
    cnt_d       = cnt;
    sra_d       = sra_q;

    case (state)
      IDLE: ;
      SHIFT: begin
        shreg_d = shifted;
        cnt_d   = cnt - SHAMT_W'(1);
        if (cnt == SHAMT_W'(1)) begin
          result_d    = shifted;
          zero_d      = (shifted == '0);
          ovf_d       = 1'b0;
          illegal_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready && !bus.in_valid) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new operation may be accepted from IDLE or from DONE while the result drains
    if (accept) begin
      if (alu_multi) begin
        shreg_d     = bus.a;
        cnt_d       = shamt;
        sra_d       = alu_sra;
        out_valid_d = 1'b0;
        state_d     = SHIFT;
      end else begin
        result_d    = alu_res;
        zero_d      = (alu_res == '0);
        ovf_d       = alu_ovf;
        illegal_d   = alu_ill;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      result_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
      shreg       <= '0;
      cnt         <= '0;
      sra_q       <= 1'b0;
    end else begin
      state       <= state_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      illegal_q   <= illegal_d;
      out_valid_q <= out_valid_d;
      shreg       <= shreg_d;
      cnt         <= cnt_d;
      sra_q       <= sra_d;
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit; obs packs {out_valid, result, zero, overflow, illegal}.
module tb_alu_exec_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  alu_exec_if #(.WIDTH(16)) bus ();

  alu_exec_unit #(.WIDTH(16), .SHAMT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  logic [19:0] obs;
  assign obs = {bus.out_valid, bus.result, bus.zero, bus.overflow, bus.illegal};

`ifdef ALU_FAST_SHIFT_EN
  localparam int SRA4_LAT  = 0;
  localparam int SLL15_LAT = 0;
`else
  localparam int SRA4_LAT  = 4;
  localparam int SLL15_LAT = 15;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [15:0] av, input logic [15:0] bv);
    bus.alu_control = op;
    bus.a           = av;
    bus.b           = bv;
    bus.in_valid    = 1'b1;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.alu_control = 4'h0; bus.a = '0; bus.b = '0;
    #3;
    checks++;
    if (obs !== 20'h0 || bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_state obs=%h in_ready=%b expected obs=00000 in_ready=1", obs, bus.in_ready);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_add_overflow();
    drive(4'b0100, 16'h7FFF, 16'h0001); tick(); bus.in_valid = 1'b0;
    checks++;
    if (obs !== {1'b1, 16'h8000, 3'b010}) begin
      failures++; $display("FAIL add_overflow obs=%h expected %h", obs, {1'b1, 16'h8000, 3'b010});
    end
    drive(4'b0100, 16'h8000, 16'h8000); tick(); bus.in_valid = 1'b0;
    checks++;
    if (obs !== {1'b1, 16'h0000, 3'b110}) begin
      failures++; $display("FAIL add_neg_overflow obs=%h expected %h", obs, {1'b1, 16'h0000, 3'b110});
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL drain_to_idle out_valid=%b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_sub_slt_logic();
    drive(4'b1100, 16'h1234, 16'h1234); tick();
    checks++;
    if (obs !== {1'b1, 16'h0000, 3'b100}) begin
      failures++; $display("FAIL sub_zero obs=%h expected %h", obs, {1'b1, 16'h0000, 3'b100});
    end
    drive(4'b1100, 16'h8000, 16'h0001); tick();
    checks++;
    if (obs !== {1'b1, 16'h7FFF, 3'b010}) begin
      failures++; $display("FAIL sub_overflow obs=%h expected %h", obs, {1'b1, 16'h7FFF, 3'b010});
    end
    drive(4'b0001, 16'hFFFF, 16'h0001); tick();
    checks++;
    if (obs !== {1'b1, 16'h0001, 3'b000}) begin
      failures++; $display("FAIL slt_true obs=%h expected %h", obs, {1'b1, 16'h0001, 3'b000});
    end
    drive(4'b0001, 16'h0001, 16'hFFFF); tick();
    checks++;
    if (obs !== {1'b1, 16'h0000, 3'b100}) begin
      failures++; $display("FAIL slt_false obs=%h expected %h", obs, {1'b1, 16'h0000, 3'b100});
    end
    drive(4'b0000, 16'hF0F0, 16'h0FF0); tick();
    checks++;
    if (obs !== {1'b1, 16'h00F0, 3'b000}) begin
      failures++; $display("FAIL and obs=%h expected %h", obs, {1'b1, 16'h00F0, 3'b000});
    end
    drive(4'b0010, 16'hF0F0, 16'h0FF0); tick();
    checks++;
    if (obs !== {1'b1, 16'hFFF0, 3'b000}) begin
      failures++; $display("FAIL or obs=%h expected %h", obs, {1'b1, 16'hFFF0, 3'b000});
    end
    drive(4'b0011, 16'hF0F0, 16'h0FF0); tick(); bus.in_valid = 1'b0;
    checks++;
    if (obs !== {1'b1, 16'hFF00, 3'b000}) begin
      failures++; $display("FAIL xor obs=%h expected %h", obs, {1'b1, 16'hFF00, 3'b000});
    end
    tick();
  endtask

  task automatic test_shift(input string name, input logic [3:0] op, input logic [15:0] av,
                            input logic [15:0] bv, input logic [15:0] exp_res, input int exp_lat);
    int  lat = 0;
    bit  ready_bad = 1'b0;
    drive(op, av, bv); tick(); bus.in_valid = 1'b0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      if (bus.in_ready !== 1'b0) ready_bad = 1'b1;
      tick();
      lat++;
    end
    checks++;
    if (lat !== exp_lat || ready_bad) begin
      failures++; $display("FAIL %s_latency edges=%0d ready_bad=%b expected edges=%0d ready_bad=0", name, lat, ready_bad, exp_lat);
    end
    checks++;
    if (obs !== {1'b1, exp_res, (exp_res == 16'h0), 2'b00}) begin
      failures++; $display("FAIL %s_result obs=%h expected %h", name, obs, {1'b1, exp_res, (exp_res == 16'h0), 2'b00});
    end
    tick();
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive(4'b0100, 16'h0002, 16'h0003); tick();
    drive(4'b0011, 16'hFFFF, 16'h0F0F);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs !== {1'b1, 16'h0005, 3'b000} || bus.in_ready !== 1'b0) begin
        failures++; $display("FAIL backpressure_hold[%0d] obs=%h in_ready=%b expected obs=%h in_ready=0", i, obs, bus.in_ready, {1'b1, 16'h0005, 3'b000});
      end
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL backpressure_release_ready in_ready=%b expected 1", bus.in_ready);
    end
    tick(); bus.in_valid = 1'b0;
    checks++;
    if (obs !== {1'b1, 16'hF0F0, 3'b000}) begin
      failures++; $display("FAIL backpressure_new_capture obs=%h expected %h", obs, {1'b1, 16'hF0F0, 3'b000});
    end
    tick();
  endtask

  task automatic test_illegal();
    drive(4'b0100, 16'h7FFF, 16'h0001); tick();
    drive(4'b1111, 16'hAAAA, 16'h5555); tick(); bus.in_valid = 1'b0;
    checks++;
    if (obs !== {1'b1, 16'h0000, 3'b101}) begin
      failures++; $display("FAIL illegal_code obs=%h expected %h", obs, {1'b1, 16'h0000, 3'b101});
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops  [4] = '{4'b0100, 4'b0100, 4'b0010, 4'b1100};
    logic [15:0] avs  [4] = '{16'h0001, 16'h0003, 16'h00F0, 16'h0005};
    logic [15:0] bvs  [4] = '{16'h0001, 16'h0004, 16'h0F00, 16'h0007};
    logic [15:0] exps [4] = '{16'h0002, 16'h0007, 16'h0FF0, 16'hFFFE};
    for (int i = 0; i < 4; i++) begin
      drive(ops[i], avs[i], bvs[i]); tick();
      checks++;
      if (obs !== {1'b1, exps[i], 3'b000}) begin
        failures++; $display("FAIL back_to_back[%0d] obs=%h expected %h", i, obs, {1'b1, exps[i], 3'b000});
      end
    end
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_op();
    drive(4'b0110, 16'h0001, 16'h000F); tick(); bus.in_valid = 1'b0;
    tick(); tick();
`ifdef ALU_FAST_SHIFT_EN
    checks++;
    if (bus.result !== 16'h8000) begin
      failures++; $display("FAIL pre_reset_result result=%h expected 8000", bus.result);
    end
`else
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL mid_shift_busy in_ready=%b out_valid=%b expected 0 0", bus.in_ready, bus.out_valid);
    end
`endif
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== 20'h0 || bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_mid_op obs=%h in_ready=%b expected obs=00000 in_ready=1", obs, bus.in_ready);
    end
    tick();
    rst = 1'b0;
    drive(4'b0100, 16'h0002, 16'h0003); tick(); bus.in_valid = 1'b0;
    checks++;
    if (obs !== {1'b1, 16'h0005, 3'b000}) begin
      failures++; $display("FAIL after_reset_add obs=%h expected %h", obs, {1'b1, 16'h0005, 3'b000});
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub_slt_logic();
    test_shift("sra4", 4'b0111, 16'h8000, 16'h0004, 16'hF800, SRA4_LAT);
    test_shift("sll15", 4'b0110, 16'h0001, 16'h000F, 16'h8000, SLL15_LAT);
    test_shift("sll0", 4'b0110, 16'h1234, 16'h0010, 16'h1234, 0);
    test_shift("sra_pos", 4'b0111, 16'h7000, 16'h0002, 16'h1C00, (SRA4_LAT == 0) ? 0 : 2);
    test_backpressure();
    test_illegal();
    test_back_to_back();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout simulation did not finish within 200000 time units");
    $fatal(1);
  end
endmodule
